// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// RESET_PC is also the core's PC reset value, so both sides agree on where code starts.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [31:0] RESET_PC       = 32'h0000_0000;

  // Byte address of instruction word idx, wrapping modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// master is the loader side; slave is the host link / memory side.
interface imem_loader_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;

  modport master (
    input  s_valid, s_data,
    output s_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles consecutive bytes into a little-endian 32-bit word.
// last_byte flags that the next loaded byte completes the word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        clr,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        last_byte
);

  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      idx  <= '0;
      word <= '0;
    end else if (load_en) begin
      word[8*idx +: 8] <= byte_data;
      idx              <= idx + 1'b1;
    end
  end

  assign last_byte = (idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a count header, then writes count little-endian words to
// consecutive instruction-memory addresses while holding the core in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  imem_loader_if.master bus,
  output logic        hold_core,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] word_cnt
);

  // Largest legal count; 17 bits so that ADDR_W=16 still fits.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t      state;
  logic [15:0] count;
  logic [15:0] hdr_count;
  logic [15:0] next_cnt;
  logic        accept;
  logic        load_en;
  logic        clr;
  logic        last_byte;
  logic [31:0] word;

  assign accept    = bus.s_valid && bus.s_ready;
  assign load_en   = accept && (state == ST_DATA);
  assign clr       = start && (state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign hdr_count = {bus.s_data, count[7:0]};
  assign next_cnt  = word_cnt + 16'd1;
  assign bus.im_wdata = word;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .clr       (clr),
    .byte_data (bus.s_data),
    .word      (word),
    .last_byte (last_byte)
  );

  // Outputs are registered alongside the state, so each transition also sets
  // the output values of the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      word_cnt    <= '0;
      bus.s_ready <= 1'b0;
      bus.im_we   <= 1'b0;
      bus.im_addr <= BASE_ADDR;
      hold_core   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state       <= ST_HDR0;
            word_cnt    <= '0;
            bus.s_ready <= 1'b1;
            bus.im_addr <= BASE_ADDR;
            hold_core   <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
          end
        end
        ST_HDR0: begin
          if (accept) begin
            count[7:0] <= bus.s_data;
            state      <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (accept) begin
            count[15:8] <= bus.s_data;
            if (hdr_count == '0) begin
              state       <= ST_DONE;
              bus.s_ready <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              hold_core   <= 1'b0;
            end else if ({1'b0, hdr_count} > MAX_WORDS) begin
              state       <= ST_ERR;
              bus.s_ready <= 1'b0;
              busy        <= 1'b0;
              err         <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept && last_byte) begin
            state       <= ST_WRITE;
            bus.s_ready <= 1'b0;
            bus.im_we   <= 1'b1;
          end
        end
        ST_WRITE: begin
          bus.im_we   <= 1'b0;
          word_cnt    <= next_cnt;
          bus.im_addr <= word_addr(BASE_ADDR, next_cnt);
          if (next_cnt == count) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            hold_core <= 1'b0;
          end else begin
            state       <= ST_DATA;
            bus.s_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances (base 0 and base 0x100)
// receive the same byte stream; table-driven loads plus hand-written corner cases.
module tb_imem_loader;
  import imem_loader_pkg::*;

  typedef struct {
    logic [7:0]  h0;
    logic [7:0]  h1;
    logic [63:0] data;
    int          nwords;
    bit          gaps;
    bit          exp_done;
    bit          exp_err;
    logic [15:0] exp_wc;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;

  imem_loader_if bus0 ();
  imem_loader_if bus1 ();

  assign bus0.s_valid = s_valid;
  assign bus0.s_data  = s_data;
  assign bus1.s_valid = s_valid;
  assign bus1.s_data  = s_data;

  logic        hold0, busy0, done0, err0;
  logic [15:0] wc0;
  logic        hold1, busy1, done1, err1;
  logic [15:0] wc1;

  imem_loader dut0 (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus0),
    .hold_core (hold0),
    .busy      (busy0),
    .done      (done0),
    .err       (err0),
    .word_cnt  (wc0)
  );

  imem_loader #(.ADDR_W(8), .BASE_ADDR(32'h0000_0100)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus1),
    .hold_core (hold1),
    .busy      (busy1),
    .done      (done1),
    .err       (err1),
    .word_cnt  (wc1)
  );

  always #5 clk = ~clk;

  logic [31:0] wa0[$];
  logic [31:0] wd0[$];
  logic [31:0] wa1[$];
  logic [31:0] wd1[$];

  always @(negedge clk) begin
    if (bus0.im_we) begin
      wa0.push_back(bus0.im_addr);
      wd0.push_back(bus0.im_wdata);
    end
    if (bus1.im_we) begin
      wa1.push_back(bus1.im_addr);
      wd1.push_back(bus1.im_wdata);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers one byte and returns #1 after the accepting edge; waits = stalled cycles.
  task automatic send_byte(input logic [7:0] b, output int waits);
    s_valid = 1'b1;
    s_data  = b;
    waits   = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus0.s_ready) begin
        @(posedge clk); #1;
        s_valid = 1'b0;
        return;
      end
      waits++;
    end
    s_valid = 1'b0;
    waits   = -1;
    chk("send_timeout", 32'd1, 32'd0);
  endtask

  vec_t vecs[6];
  vec_t v;
  int   w;
  bit   timeout;
  logic [7:0] b;

  initial begin
    vecs[0] = '{h0:8'h02, h1:8'h00, data:64'hDDCC_BBAA_4433_2211, nwords:2, gaps:0, exp_done:1, exp_err:0, exp_wc:16'd2};
    vecs[1] = '{h0:8'h00, h1:8'h00, data:64'h0,                   nwords:0, gaps:0, exp_done:1, exp_err:0, exp_wc:16'd0};
    vecs[2] = '{h0:8'h01, h1:8'h01, data:64'h0,                   nwords:0, gaps:0, exp_done:0, exp_err:1, exp_wc:16'd0};
    vecs[3] = '{h0:8'h02, h1:8'h00, data:64'hDDCC_BBAA_4433_2211, nwords:2, gaps:1, exp_done:1, exp_err:0, exp_wc:16'd2};
    vecs[4] = '{h0:8'h01, h1:8'h00, data:64'h0000_0000_DEAD_BEEF, nwords:1, gaps:0, exp_done:1, exp_err:0, exp_wc:16'd1};
    vecs[5] = '{h0:8'h01, h1:8'h02, data:64'h0,                   nwords:0, gaps:0, exp_done:0, exp_err:1, exp_wc:16'd0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready",  bus0.s_ready,  32'd0);
    chk("rst_im_we",    bus0.im_we,    32'd0);
    chk("rst_im_addr0", bus0.im_addr,  32'h0);
    chk("rst_im_addr1", bus1.im_addr,  32'h100);
    chk("rst_im_wdata", bus0.im_wdata, 32'h0);
    chk("rst_hold",     hold0, 32'd1);
    chk("rst_busy",     busy0, 32'd0);
    chk("rst_done",     done0, 32'd0);
    chk("rst_err",      err0,  32'd0);
    chk("rst_wc",       wc0,   32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_hold", hold0, 32'd1);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      clear_log();
      pulse_start();
      chk("busy_after_start", busy0, 32'd1);
      send_byte(v.h0, w);
      send_byte(v.h1, w);
      if (v.exp_err) chk("err_after_hdr", err0, 32'd1);
      if (v.nwords == 0 && !v.exp_err) chk("zero_done_after_hdr", done0, 32'd1);
      for (int j = 0; j < 4 * v.nwords; j++) begin
        if (v.gaps) begin
          repeat (j % 3) @(posedge clk);
          #1;
        end
        b = v.data[8*j +: 8];
        send_byte(b, w);
        if (!v.gaps && j > 0 && (j % 4) == 0) chk("write_bubble", w, 32'd1);
        if ((j % 4) == 3) begin
          chk("we_after_4th", bus0.im_we, 32'd1);
          chk("ready_in_write", bus0.s_ready, 32'd0);
        end
      end
      timeout = 1'b1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (done0 || err0) begin
          timeout = 1'b0;
          break;
        end
      end
      chk("finish_timeout", timeout, 32'd0);
      chk("done",   done0, v.exp_done);
      chk("err",    err0,  v.exp_err);
      chk("hold",   hold0, !v.exp_done);
      chk("busy",   busy0, 32'd0);
      chk("wc",     wc0,   v.exp_wc);
      chk("nwr0",   wa0.size(), v.nwords);
      chk("nwr1",   wa1.size(), v.nwords);
      for (int k = 0; k < v.nwords && k < wa0.size() && k < wa1.size(); k++) begin
        chk("wr_addr0", wa0[k], 32'(4 * k));
        chk("wr_addr1", wa1[k], 32'h100 + 32'(4 * k));
        chk("wr_data0", wd0[k], v.data[32*k +: 32]);
        chk("wr_data1", wd1[k], v.data[32*k +: 32]);
      end
      @(posedge clk); #1;
    end

    // Maximum count: 256 words, byte j carries j mod 256
    clear_log();
    pulse_start();
    send_byte(8'h00, w);
    send_byte(8'h01, w);
    for (int j = 0; j < 1024; j++) begin
      b = 8'(j);
      send_byte(b, w);
    end
    chk("max_hold_in_write", hold1, 32'd1);
    @(posedge clk); #1;
    chk("max_done", done1, 32'd1);
    chk("max_hold", hold1, 32'd0);
    chk("max_wc",   wc1,   32'd256);
    chk("max_nwr",  wa1.size(), 32'd256);
    if (wa1.size() == 256 && wa0.size() == 256) begin
      chk("max_first_addr", wa1[0],   32'h100);
      chk("max_last_addr",  wa1[255], 32'h4FC);
      chk("max_last_data",  wd1[255], 32'hFFFE_FDFC);
      chk("max_last_addr0", wa0[255], 32'h3FC);
    end

    // Reset mid-load after 6 data bytes, with an ignored start inside DATA
    @(posedge clk); #1;
    clear_log();
    pulse_start();
    send_byte(8'h02, w);
    send_byte(8'h00, w);
    send_byte(8'h11, w);
    send_byte(8'h22, w);
    send_byte(8'h33, w);
    send_byte(8'h44, w);
    send_byte(8'hAA, w);
    pulse_start();
    chk("start_ignored_busy", busy0, 32'd1);
    chk("start_ignored_wc",   wc0,   32'd1);
    send_byte(8'hBB, w);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_hold",  hold0, 32'd1);
    chk("mid_rst_wc",    wc0,   32'd0);
    chk("mid_rst_busy",  busy0, 32'd0);
    chk("mid_rst_ready", bus0.s_ready, 32'd0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_nwr",   wa0.size(), 32'd1);
    chk("mid_rst_hold2", hold0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
